uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  UART transmitter with an input FIFO. Mirrors uart_rx, the receiver side of the board UART link.
//  Accepts bytes on a valid/ready stream and serializes them onto o_UART_TX-style line: 8N1, LSB first.
//  Lets logic return memory/lookup results to the host without stalling the producer per byte.
// PARAMETERS
//  CLK_FREQ   25_000_000  system clock frequency, Hz
//  BAUD_RATE  115200      line rate, bits/s; DIV = CLK_FREQ/BAUD_RATE (integer, truncated; 217 at defaults)
//  N_BITS     8           data bits per frame
//  FIFO_AW    2           FIFO address width; depth = 2**FIFO_AW (4 at default)
// PORTS
//  clk             in   1          system clock, all logic on posedge
//  rst             in   1          synchronous, active-high reset
//  uart_tx_tdata   in   N_BITS     byte to send
//  uart_tx_tvalid  in   1          producer has a byte on tdata
//  uart_tx_tready  out  1          FIFO can accept; = !full, registered, no comb path from tvalid
//  tx_data         out  1          serial line, idle high, registered
//  busy            out  1          high while a frame is on the line or FIFO not empty
//  fifo_count      out  FIFO_AW+1  number of bytes stored, 0..2**FIFO_AW
// BEHAVIOUR
//  Reset: tx_data=1, uart_tx_tready=1, busy=0, fifo_count=0; FIFO pointers cleared, FSM->IDLE, baud cnt=0.
//  Reset mid-frame aborts the frame: tx_data=1 after the reset edge; queued bytes discarded.
//  Push: on edge where tvalid&&tready, tdata written; count+1. tready=0 when count==depth; writes ignored.
//  Pop: FSM in IDLE (or at end of STOP) with count>0 pops head; push+pop same edge -> count unchanged.
//  FSM states: IDLE, START, DATA, STOP.
//   IDLE : tx_data=1. count>0 -> pop, load shift reg, START (tx_data=0 from this edge).
//   START: hold 0 for DIV cycles -> DATA, bit_idx=0.
//   DATA : tx_data=shift[0], each bit DIV cycles, shift right; after bit N_BITS-1 -> STOP.
//   STOP : tx_data=1 for DIV cycles; then count>0 -> pop, START directly (no idle gap), else IDLE.
//  Baud counter 0..DIV-1, restarts at every state entry; every line bit exactly DIV cycles.
//  Frame = (N_BITS+2)*DIV cycles. Latency: byte pushed at edge k into empty FIFO, idle FSM ->
//   start bit driven from edge k+1.
//  Wraparound: FIFO pointers FIFO_AW bits, wrap mod depth; count disambiguates full/empty.
//  busy = (state!=IDLE) | (count!=0), registered with state.
//  Data bits taken only from popped FIFO entry; tdata changes after acceptance have no effect.
// TESTING (sim with CLK_FREQ=8, BAUD_RATE=1 -> DIV=8, FIFO_AW=2)
//  1 push 0xA5 into idle -> start bit next edge; line 0,1,0,1,0,0,1,0,1,1, each 8 cycles; busy drops after 80.
//  2 push 0x00 then 0xFF back-to-back -> 160 cycles frames contiguous, no idle cycle between stop and start.
//  3 hold tvalid with 6 bytes -> 5 accepted before tready=0 (1 popped + 4 stored); tready re-asserts 1 cycle
//    after next pop; all 6 bytes sent in order, none duplicated or lost.
//  4 assert rst at cycle 30 of a 0x3C frame with 2 queued -> tx_data=1, count=0, busy=0 after edge; no further frames.
//  5 push on the same edge a pop occurs (count=2) -> count stays 2; pointer wrap over 10 bytes keeps order.
//  6 random bytes, random tvalid gaps, 200 frames -> scoreboard via uart_rx loopback matches exactly.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: byte stream from a producer into the UART transmitter FIFO.
//   uart_tx_tdata   byte to send (N_BITS wide)
//   uart_tx_tvalid  producer has a byte on tdata
//   uart_tx_tready  transmitter FIFO can accept this cycle
// Modports: master = producer side, slave = uart_tx_fifo side.
interface uart_tx_fifo_if #(
  parameter int N_BITS = 8
);
  logic [N_BITS-1:0] uart_tx_tdata;
  logic              uart_tx_tvalid;
  logic              uart_tx_tready;

  modport master (output uart_tx_tdata, output uart_tx_tvalid, input  uart_tx_tready);
  modport slave  (input  uart_tx_tdata, input  uart_tx_tvalid, output uart_tx_tready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter (LSB first) fed by a small byte FIFO so a
// producer can hand over a burst of bytes without waiting for each frame.
// Ports:
//   clk         system clock, all logic on posedge
//   rst         synchronous active-high reset; aborts any frame, empties FIFO
//   tx_in       slave stream port (uart_tx_tdata/uart_tx_tvalid/uart_tx_tready)
//   tx_data     serial line, idle high, registered
//   busy        frame on the line or bytes still queued, registered
//   fifo_count  bytes held in the FIFO, 0..2**FIFO_AW
module uart_tx_fifo #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int N_BITS    = 8,
  parameter int FIFO_AW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_fifo_if.slave      tx_in,
  output logic               tx_data,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count
);
  localparam int DIV   = CLK_FREQ / BAUD_RATE;
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW    = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int NW    = FIFO_AW + 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(N_BITS - 1);
  localparam logic [NW-1:0] COUNT_FULL = NW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       baud_q, baud_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [N_BITS-1:0]   shift_q, shift_d;
  logic                tx_d;

  logic [N_BITS-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
  logic [NW-1:0]       count_d;
  logic                tready_q;
  logic                push, pop;

  assign tx_in.uart_tx_tready = tready_q;
  assign push = tx_in.uart_tx_tvalid && tready_q;

  // Line output is computed for the next cycle and registered, so the bit
  // value changes on the same edge as the state transition that selects it.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_data;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (fifo_count != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_q == CNT_LAST) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (baud_q == CNT_LAST) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end
      end
      STOP: begin
        if (baud_q == CNT_LAST) begin
          baud_d = '0;
          // Back-to-back frames: go straight to START with no idle bit.
          if (fifo_count != '0) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    count_d = fifo_count + NW'(push) - NW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_data    <= 1'b1;
      busy       <= 1'b0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tready_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_data    <= tx_d;
      fifo_count <= count_d;
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      // Ready is derived from the post-edge count so it is registered yet
      // never lets a push through into a full FIFO.
      tready_q   <= (count_d != COUNT_FULL);
      busy       <= (state_d != IDLE) || (count_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_in.uart_tx_tdata;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and randomized checks of uart_tx_fifo with
// DIV = 8, FIFO depth 4. A time-based reference model (queue of stored bytes
// plus cycles elapsed in the current frame) predicts every output each cycle,
// and a line decoder recovers transmitted bytes and compares them in order
// with the accepted bytes.
module tb_uart_tx_fifo;
  localparam int CLK_FREQ  = 8;
  localparam int BAUD_RATE = 1;
  localparam int N_BITS    = 8;
  localparam int FIFO_AW   = 2;
  localparam int D         = CLK_FREQ / BAUD_RATE;
  localparam int DEPTH     = 2 ** FIFO_AW;
  localparam int FRAME     = (N_BITS + 2) * D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_data;
  logic busy;
  logic [FIFO_AW:0] fifo_count;

  uart_tx_fifo_if #(.N_BITS(N_BITS)) bus ();

  uart_tx_fifo #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE),
    .N_BITS   (N_BITS),
    .FIFO_AW  (FIFO_AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_in     (bus.slave),
    .tx_data   (tx_data),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  byte unsigned m_q[$];
  byte unsigned acc_q[$];
  int           m_t = -1;
  byte unsigned m_cur = 0;
  bit           m_rdy = 1'b1;

  // Line decoder state
  bit           rx_busy = 1'b0;
  int           rx_t = 0;
  byte unsigned rx_byte = 0;
  int           frames_rx = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_tx();
    int b;
    if (m_t < 0) return 1'b1;
    b = m_t / D;
    if (b == 0) return 1'b0;
    if (b <= N_BITS) return m_cur[b-1];
    return 1'b1;
  endfunction

  task automatic rx_sample();
    byte unsigned want;
    if (!rx_busy) begin
      if (tx_data === 1'b0) begin
        rx_busy = 1'b1;
        rx_t    = 0;
        rx_byte = 0;
      end
    end else begin
      rx_t++;
      if (rx_t >= D + D/2 && rx_t < (N_BITS + 1) * D && ((rx_t - D/2) % D) == 0)
        rx_byte[(rx_t - D - D/2) / D] = tx_data;
      if (rx_t == (N_BITS + 1) * D + D/2) begin
        chk("rx_stop_bit", tx_data, 1);
        chk("rx_frame_expected", acc_q.size() != 0, 1);
        if (acc_q.size() != 0) begin
          want = acc_q.pop_front();
          chk("rx_byte", rx_byte, want);
        end
        frames_rx++;
        rx_busy = 1'b0;
      end
    end
  endtask

  // Advance the model across one clock edge, take the edge, check outputs.
  task automatic step();
    bit acc;
    int nt;
    if (rst) begin
      m_q.delete();
      acc_q.delete();
      m_t     = -1;
      m_rdy   = 1'b1;
      rx_busy = 1'b0;
    end else begin
      acc = (bus.uart_tx_tvalid === 1'b1) && m_rdy;
      nt  = (m_t < 0) ? -1 : m_t + 1;
      if (nt == FRAME) nt = -1;
      if (nt < 0 && m_q.size() != 0) begin
        m_cur = m_q.pop_front();
        nt    = 0;
      end
      m_t = nt;
      if (acc) begin
        m_q.push_back(bus.uart_tx_tdata);
        acc_q.push_back(bus.uart_tx_tdata);
      end
      m_rdy = (m_q.size() != DEPTH);
    end
    @(posedge clk);
    #1;
    chk("tx_data", tx_data, exp_tx());
    chk("fifo_count", fifo_count, m_q.size());
    chk("busy", busy, (m_t >= 0) || (m_q.size() != 0));
    chk("tready", bus.uart_tx_tready, m_rdy);
    rx_sample();
  endtask

  task automatic drain(input string tag, input int limit);
    int n = 0;
    bus.uart_tx_tvalid = 1'b0;
    while (busy !== 1'b0 && n < limit) begin
      step();
      n++;
    end
    chk(tag, busy, 0);
    chk({tag, "_rx_pending"}, acc_q.size(), 0);
  endtask

  task automatic push_held(input string tag, input int nbytes, input int limit);
    int sent = 0;
    int cyc = 0;
    int before_stall = -1;
    byte unsigned b;
    bus.uart_tx_tvalid = 1'b1;
    b = 8'($urandom);
    while (sent < nbytes && cyc < limit) begin
      bus.uart_tx_tdata = b;
      if (bus.uart_tx_tready === 1'b1) begin
        sent++;
        b = 8'($urandom);
      end else if (before_stall < 0) begin
        before_stall = sent;
      end
      step();
      cyc++;
    end
    bus.uart_tx_tvalid = 1'b0;
    chk({tag, "_accepted"}, sent, nbytes);
    if (nbytes > DEPTH + 1) chk({tag, "_before_stall"}, before_stall, DEPTH + 1);
  endtask

  initial begin
    int n;
    int n_low;
    int acc_n;
    int cyc;
    int frames_start;

    bus.uart_tx_tvalid = 1'b0;
    bus.uart_tx_tdata  = '0;
    rst = 1'b1;
    step();
    step();
    chk("reset_tx", tx_data, 1);
    chk("reset_count", fifo_count, 0);
    chk("reset_busy", busy, 0);
    chk("reset_tready", bus.uart_tx_tready, 1);
    rst = 1'b0;
    step();

    // Single 0xA5 frame: start bit on the edge after the push, busy 80 cycles.
    bus.uart_tx_tvalid = 1'b1;
    bus.uart_tx_tdata  = 8'hA5;
    step();
    bus.uart_tx_tvalid = 1'b0;
    bus.uart_tx_tdata  = 8'h5A;
    step();
    chk("t1_start_bit", tx_data, 0);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("t1_busy_after_start", n + 1, 81);
    chk("t1_rx_pending", acc_q.size(), 0);
    repeat (5) step();

    // 0x00 then 0xFF back to back: 160 contiguous cycles.
    bus.uart_tx_tvalid = 1'b1;
    bus.uart_tx_tdata  = 8'h00;
    step();
    bus.uart_tx_tdata  = 8'hFF;
    step();
    bus.uart_tx_tvalid = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      step();
      n++;
    end
    chk("t2_busy_cycles", n, 160);
    repeat (3) step();

    // Held tvalid with 6 bytes: 5 accepted before the first stall.
    push_held("t3", 6, 2000);
    drain("t3_drain", 1000);

    // Reset 30 cycles into a 0x3C frame with two bytes queued.
    bus.uart_tx_tvalid = 1'b1;
    bus.uart_tx_tdata  = 8'h3C;
    step();
    bus.uart_tx_tdata  = 8'h11;
    step();
    bus.uart_tx_tdata  = 8'h22;
    step();
    bus.uart_tx_tvalid = 1'b0;
    n = 0;
    while (m_t != 30 && n < 100) begin
      step();
      n++;
    end
    chk("t4_reached_cycle30", fifo_count, 2);
    rst = 1'b1;
    step();
    chk("t4_rst_tx", tx_data, 1);
    chk("t4_rst_count", fifo_count, 0);
    chk("t4_rst_busy", busy, 0);
    rst = 1'b0;
    n_low = 0;
    repeat (200) begin
      step();
      if (tx_data !== 1'b1) n_low++;
    end
    chk("t4_no_frames", n_low, 0);

    // Push on the same edge as a pop with count 2, then wrap over 10 bytes.
    bus.uart_tx_tvalid = 1'b1;
    bus.uart_tx_tdata  = 8'h81;
    step();
    bus.uart_tx_tdata  = 8'h42;
    step();
    bus.uart_tx_tdata  = 8'h24;
    step();
    bus.uart_tx_tvalid = 1'b0;
    n = 0;
    while (m_t != FRAME - 1 && n < 200) begin
      step();
      n++;
    end
    chk("t5_count_before", fifo_count, 2);
    bus.uart_tx_tvalid = 1'b1;
    bus.uart_tx_tdata  = 8'h77;
    step();
    bus.uart_tx_tvalid = 1'b0;
    chk("t5_count_push_pop", fifo_count, 2);
    chk("t5_next_start", tx_data, 0);
    drain("t5_drain", 1000);
    push_held("t5_wrap", 10, 3000);
    drain("t5_wrap_drain", 1000);

    // Random bytes with random tvalid gaps, 200 frames.
    frames_start = frames_rx;
    acc_n = 0;
    cyc = 0;
    while (acc_n < 200 && cyc < 40000) begin
      bus.uart_tx_tvalid = ($urandom_range(0, 3) != 0);
      bus.uart_tx_tdata  = 8'($urandom);
      if (bus.uart_tx_tvalid && bus.uart_tx_tready === 1'b1) acc_n++;
      step();
      cyc++;
      if ($urandom_range(0, 15) == 0) repeat ($urandom_range(1, 120)) begin
        bus.uart_tx_tvalid = 1'b0;
        bus.uart_tx_tdata  = 8'($urandom);
        step();
        cyc++;
      end
    end
    bus.uart_tx_tvalid = 1'b0;
    chk("t6_accepted", acc_n, 200);
    drain("t6_drain", 2000);
    chk("t6_frames", frames_rx - frames_start, 200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
